priority_encoder_q: RTL and testbench
=====================================

# priority_encoder_q

Sequential 4-to-2 encoder; the encode-side counterpart of the team's 2-to-4 active-high decoders. Collects active-high request lines d0..d3 into a pending register and emits one 2-bit code (s1,s0) per request over a valid/ready handshake, in priority order. Sits upstream of a decoder so that requests raised in the same cycle are serialised, not lost.

## Interface
- No parameters; width is fixed at 4 lines / 2-bit code.
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- d0, d1, d2, d3  input  1 each  request lines; active high; a high level is a request in every cycle it is high.
- s0  output  1  code LSB.
- s1  output  1  code MSB; {s1,s0}=i for line di.
- valid  output  1  code on s1,s0 is presented.
- ready  input  1  consumer accepts code when valid&&ready at a clock edge.
- drop  output  1  one-cycle pulse: request seen on a line already pending and not being cleared.
- idle  output  1  pending==0 and valid==0.

## Operation
- State: pending[3:0], output register {s1,s0}, valid; FSM with two states, EMPTY (valid=0) and PRESENT (valid=1).
- Per edge: req = {d3,d2,d1,d0}; merged = pending | req.
- Load condition: valid==0, or valid&&ready (accept). When load and merged!=0: select index i from merged per priority rule, drive {s1,s0}=i, valid=1, pending = merged with bit i cleared. When load and merged==0: valid=0, {s1,s0} hold last value, pending=0.
- No load (valid&&!ready): {s1,s0}, valid held stable; pending = pending | req.
- Fixed priority (default): d0 highest, d3 lowest.
- A request on the line currently presented but already accepted this edge is treated as new: it re-enters pending.
- drop=1 for the cycle after an edge where req[j]=1 and pending[j]=1 and bit j is not selected at that edge; request is merged (no loss of information beyond the duplicate).
- Transitions: EMPTY->PRESENT when merged!=0; PRESENT->EMPTY on accept with merged==0; PRESENT->PRESENT on accept with merged!=0 or on stall.

## Timing
- Reset (rst_n=0 at edge): pending=0, s1=0, s0=0, valid=0, drop=0, idle=1; reset wins over any simultaneous request or accept.
- Latency: request high at edge k with block EMPTY -> valid=1 with its code after edge k (one cycle).
- Throughput: one code per cycle while ready=1.
- Stability: while valid&&!ready, s1,s0,valid do not change.
- Reset mid-operation discards all pending requests and the presented code.

## Configuration
- PRIORITY_ENCODER_Q_RR_EN defined: round-robin priority. 2-bit pointer last, reset 3; search begins at (last+1) mod 4, wraps 3->0; last updated to i on every load with merged!=0.
- Not defined: fixed priority d0>d1>d2>d3; no pointer register.

## Structure
- Shared package: code width constant (2), line count constant (4), FSM state enum {EMPTY, PRESENT}.
- One sub-module natural: pq_select, combinational pick of index and found flag from a 4-bit vector plus start pointer (pointer tied to 0 when the macro is off).

## Test plan
- Reset: hold rst_n=0 two cycles with d0..d3=1 -> valid=0, s1s0=00, idle=1, drop=0.
- Single request: d2 pulsed one cycle, ready=1 -> next cycle valid=1, s1s0=10; following cycle valid=0, idle=1.
- Simultaneous: d0..d3 pulsed together, ready=1 -> codes 00,01,10,11 on four consecutive cycles (fixed) ; with RR_EN from reset also 00,01,10,11, and second burst after last=1 gives 10,11,00,01.
- Backpressure: d1,d3 pulsed, ready=0 for 5 cycles -> s1s0=01 held stable, valid=1; then ready=1 -> 01 accepted, 11 next.
- Duplicate: d3 high for 3 cycles while ready=0 and 00 presented -> drop pulses twice, only one 11 later emitted.
- Reset mid-burst: rst_n=0 while 3 requests pending -> all outputs reset values, no stale code after release.

Source files
------------

// File: rtl/priority_encoder_q_pkg.sv
// Shared constants and FSM state type for the queued 4-to-2 priority encoder.
package priority_encoder_q_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_encoder_q_select.sv
// Combinational pick of the first set bit in vec, searching upward from start with wrap.
module pq_select
    import priority_encoder_q_pkg::*;
(
    input  logic [LINES-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] idx,
    output logic              found
);

    logic [CODE_W-1:0] pos;

    // Walk from the farthest position back to start so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = LINES - 1; k >= 0; k--) begin
            pos = start + k[CODE_W-1:0];
            if (vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_q.sv
// Sequential 4-to-2 encoder with pending register and valid/ready output.
// Define PRIORITY_ENCODER_Q_RR_EN for round-robin priority instead of d0-first.
module priority_encoder_q
    import priority_encoder_q_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic ready,
    output logic s0,
    output logic s1,
    output logic valid,
    output logic drop,
    output logic idle
);

    state_t            state;
    logic [LINES-1:0]  pending;
    logic [CODE_W-1:0] code;
    logic              drop_q;

    logic [LINES-1:0]  req;
    logic [LINES-1:0]  merged;
    logic [LINES-1:0]  sel_mask;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] idx;
    logic              found;
    logic              load;

    assign req    = {d3, d2, d1, d0};
    assign merged = pending | req;
    assign load   = (state == EMPTY) || ready;

`ifdef PRIORITY_ENCODER_Q_RR_EN
    logic [CODE_W-1:0] last;

    assign start = last + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= 2'd3;
        end else if (load && found) begin
            last <= idx;
        end
    end
`else
    assign start = '0;
`endif

    pq_select u_select (
        .vec   (merged),
        .start (start),
        .idx   (idx),
        .found (found)
    );

    // Only the line leaving pending at this edge is exempt from duplicate detection.
    assign sel_mask = (load && found) ? (4'b0001 << idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            pending <= '0;
            code    <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= |(req & pending & ~sel_mask);
            if (load) begin
                if (found) begin
                    state   <= PRESENT;
                    code    <= idx;
                    pending <= merged & ~sel_mask;
                end else begin
                    state   <= EMPTY;
                    pending <= '0;
                end
            end else begin
                pending <= merged;
            end
        end
    end

    assign s0    = code[0];
    assign s1    = code[1];
    assign valid = (state == PRESENT);
    assign drop  = drop_q;
    assign idle  = (pending == '0) && (state == EMPTY);

endmodule

// File: tb/tb_priority_encoder_q.sv
// Bench for priority_encoder_q: per-cycle model compare plus directed literal checks.
module tb_priority_encoder_q;

    logic clk;
    logic rst_n;
    logic d0, d1, d2, d3;
    logic ready;
    logic s0, s1, valid, drop, idle;

    int errors = 0;
    int checks = 0;

    priority_encoder_q dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .ready (ready),
        .s0    (s0),
        .s1    (s1),
        .valid (valid),
        .drop  (drop),
        .idle  (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: set of waiting lines, presented code, pointer for round-robin.
    int m_pend[4];
    int m_valid;
    int m_code;
    int m_drop;
    int m_last;
    bit started = 1'b0;

    always @(posedge clk) begin
        int rq[4];
        int sel;
        int ld;
        int j;
        rq[0] = d0; rq[1] = d1; rq[2] = d2; rq[3] = d3;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_pend[k] = 0;
            m_valid = 0;
            m_code  = 0;
            m_drop  = 0;
            m_last  = 3;
        end else begin
            ld  = (m_valid == 0) || ready;
            sel = -1;
            if (ld) begin
                for (int k = 0; k < 4; k++) begin
`ifdef PRIORITY_ENCODER_Q_RR_EN
                    j = (m_last + 1 + k) % 4;
`else
                    j = k;
`endif
                    if (sel < 0 && (m_pend[j] != 0 || rq[j] != 0)) sel = j;
                end
            end
            m_drop = 0;
            for (int k = 0; k < 4; k++)
                if (rq[k] != 0 && m_pend[k] != 0 && k != sel) m_drop = 1;
            for (int k = 0; k < 4; k++)
                if (rq[k] != 0) m_pend[k] = 1;
            if (ld) begin
                if (sel >= 0) begin
                    m_valid     = 1;
                    m_code      = sel;
                    m_pend[sel] = 0;
                    m_last      = sel;
                end else begin
                    m_valid = 0;
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        int any;
        if (started) begin
            any = 0;
            for (int k = 0; k < 4; k++) any |= m_pend[k];
            chk("model_valid", valid, m_valid);
            chk("model_code", {s1, s0}, m_code);
            chk("model_drop", drop, m_drop);
            chk("model_idle", idle, (any == 0 && m_valid == 0) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    int burst[4];
    int bp_first;
    int bp_second;

    initial begin
`ifdef PRIORITY_ENCODER_Q_RR_EN
        burst = '{3, 0, 1, 2};
        bp_first  = 3;
        bp_second = 1;
`else
        burst = '{0, 1, 2, 3};
        bp_first  = 1;
        bp_second = 3;
`endif
        rst_n = 1'b0;
        ready = 1'b1;
        set_d(4'b1111);
        step();
        step();
        chk("rst_valid", valid, 0);
        chk("rst_code", {s1, s0}, 0);
        chk("rst_idle", idle, 1);
        chk("rst_drop", drop, 0);

        rst_n = 1'b1;
        set_d(4'b0000);
        step();
        set_d(4'b0100);
        step();
        set_d(4'b0000);
        chk("single_valid", valid, 1);
        chk("single_code", {s1, s0}, 2);
        step();
        chk("single_done_valid", valid, 0);
        chk("single_done_idle", idle, 1);

        set_d(4'b1111);
        step();
        set_d(4'b0000);
        for (int k = 0; k < 4; k++) begin
            chk("burst_valid", valid, 1);
            chk("burst_code", {s1, s0}, burst[k]);
            step();
        end
        chk("burst_end_valid", valid, 0);

        ready = 1'b0;
        set_d(4'b1010);
        step();
        set_d(4'b0000);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", valid, 1);
            chk("bp_hold_code", {s1, s0}, bp_first);
            step();
        end
        ready = 1'b1;
        step();
        chk("bp_next_code", {s1, s0}, bp_second);
        step();
        chk("bp_end_valid", valid, 0);

        ready = 1'b0;
        set_d(4'b0001);
        step();
        chk("dup_present", {s1, s0}, 0);
        set_d(4'b1000);
        step();
        chk("dup_drop0", drop, 0);
        step();
        chk("dup_drop1", drop, 1);
        step();
        chk("dup_drop2", drop, 1);
        set_d(4'b0000);
        step();
        chk("dup_drop_clear", drop, 0);
        ready = 1'b1;
        step();
        chk("dup_one_code", {s1, s0}, 3);
        chk("dup_one_valid", valid, 1);
        step();
        chk("dup_no_repeat", valid, 0);

        ready = 1'b0;
        set_d(4'b0111);
        step();
        set_d(4'b1000);
        step();
        set_d(4'b0000);
        rst_n = 1'b0;
        step();
        chk("midrst_valid", valid, 0);
        chk("midrst_code", {s1, s0}, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_drop", drop, 0);
        rst_n = 1'b1;
        step();
        ready = 1'b1;
        step();
        chk("midrst_no_stale", valid, 0);
        chk("midrst_idle_after", idle, 1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
